// File: rtl/autocorrelation.sv
// Tempo estimator: keeps the last N spectral-flux frames in a circular buffer.
// On a beat trigger it autocorrelates the frozen history over a beat-period lag
// window, selects the strongest lag and converts it to a clamped BPM value.
module autocorrelation #(
  parameter int W           = 16,
  parameter int N           = 64,
  parameter int MIN_BPM     = 60,
  parameter int MAX_BPM     = 120,
  parameter int UPPER_LAG   = 800,
  parameter int LOWER_LAG   = 300,
  parameter int SAMPLE_RATE = 12000,
  parameter int FRAME_SIZE  = 1024,
  parameter int STRIDE      = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flux_valid,
  input  logic [W-1:0] flux_in,
  input  logic         beat_valid,
  output logic [15:0]  BPM_estimate,
  output logic         bpm_valid,
  output logic [1:0]   state_out
);

  // ---------------------------------------------------------------------------
  // Elaboration constants
  // ---------------------------------------------------------------------------
  localparam int AW           = $clog2(N);
  localparam int ACC_W        = 2*W + AW;
  localparam int HOP          = FRAME_SIZE / STRIDE;
  localparam int LOWER_LAG_FR = (LOWER_LAG * SAMPLE_RATE) / (1000 * HOP);
  localparam int UPPER_LAG_FR = (UPPER_LAG * SAMPLE_RATE) / (1000 * HOP);

  localparam logic [AW-1:0] LOW_L  = AW'(LOWER_LAG_FR);
  localparam logic [AW-1:0] UP_L   = AW'(UPPER_LAG_FR);
  localparam logic [AW-1:0] LAST_K = AW'(N - 1);
  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [AW:0]   FULL   = (AW+1)'(N);
  localparam logic [AW:0]   ONE_F  = (AW+1)'(1);
  localparam logic [31:0]   BPM_NUM = 32'(60 * SAMPLE_RATE);
  localparam logic [32:0]   HOP_W   = 33'(HOP);
  localparam logic [31:0]   MIN_W   = 32'(MIN_BPM);
  localparam logic [31:0]   MAX_W   = 32'(MAX_BPM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORR = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic [W-1:0]     mem [0:N-1];
  logic [AW-1:0]    wp_reg;
  logic [AW:0]      fill_reg, fill_next;
  logic             wr_en, start;

  // Read-address generation (lag / index counters)
  logic [AW-1:0]    lag_reg, k_reg;
  logic             issue_done_reg;
  logic             issue;
  logic [AW-1:0]    rd_addr_a, rd_addr_b;

  // Registered-read stage: operands plus tags describing where they came from
  logic [W-1:0]     a_reg, b_reg;
  logic             rd_valid_reg, rd_last_reg, rd_first_reg, rd_final_reg;
  logic [AW-1:0]    rd_lag_reg;

  // Accumulate / best-lag stage
  logic [ACC_W-1:0] acc_reg, acc_sum, best_val_reg;
  logic [AW-1:0]    best_lag_reg;
  logic             corr_end;

  // Restoring divider
  logic [31:0]      q_reg, q_next;
  logic [31:0]      rem_reg;
  logic [32:0]      rem_shift, divisor;
  logic             rem_ge;
  logic [4:0]       div_cnt_reg;
  logic             div_last;
  logic [15:0]      bpm_clamped;

  logic [15:0]      bpm_reg;
  logic             bpm_valid_reg;

  // ---------------------------------------------------------------------------
  // Combinational helpers: buffer control, addresses, MAC sum, divider step
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en     = (state_reg == IDLE) && flux_valid;
    fill_next = (wr_en && (fill_reg != FULL)) ? fill_reg + ONE_F : fill_reg;
    // A sample arriving with the trigger counts towards the full check, so it
    // is written first and included in the correlation.
    start     = (state_reg == IDLE) && beat_valid && (fill_next == FULL);

    issue     = (state_reg == CORR) && !issue_done_reg;
    // x[k] = buf[(wp+k) mod N]; N is a power of two so AW-bit wrap is the mod.
    rd_addr_a = wp_reg + k_reg;
    rd_addr_b = wp_reg + k_reg - lag_reg;

    acc_sum   = acc_reg + ACC_W'(a_reg) * ACC_W'(b_reg);
    corr_end  = rd_valid_reg && rd_last_reg && rd_final_reg;

    divisor   = 33'(best_lag_reg) * HOP_W;
    rem_shift = {rem_reg, q_reg[31]};
    rem_ge    = (rem_shift >= divisor);
    q_next    = {q_reg[30:0], rem_ge};
    div_last  = (div_cnt_reg == 5'd31);

    if (q_next < MIN_W) begin
      bpm_clamped = MIN_W[15:0];
    end else if (q_next > MAX_W) begin
      bpm_clamped = MAX_W[15:0];
    end else begin
      bpm_clamped = q_next[15:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)    state_next = CORR;
      CORR:    if (corr_end) state_next = DIV;
      DIV:     if (div_last) state_next = DONE;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // History buffer storage with registered dual read (no reset on contents)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp_reg] <= flux_in;
    end
    a_reg <= mem[rd_addr_a];
    b_reg <= mem[rd_addr_b];
  end

  // Write pointer and saturating fill count; frozen outside IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_reg   <= '0;
      fill_reg <= '0;
    end else begin
      if (wr_en) begin
        wp_reg <= wp_reg + ONE_A;
      end
      fill_reg <= fill_next;
    end
  end

  // Lag/index sweep: k runs L..N-1 for each lag, lags ascend, one read pair per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lag_reg        <= '0;
      k_reg          <= '0;
      issue_done_reg <= 1'b0;
    end else if (start) begin
      lag_reg        <= LOW_L;
      k_reg          <= LOW_L;
      issue_done_reg <= 1'b0;
    end else if (issue) begin
      if (k_reg == LAST_K) begin
        if (lag_reg == UP_L) begin
          issue_done_reg <= 1'b1;
        end else begin
          lag_reg <= lag_reg + ONE_A;
          k_reg   <= lag_reg + ONE_A;
        end
      end else begin
        k_reg <= k_reg + ONE_A;
      end
    end
  end

  // Tags travelling alongside the registered read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      rd_first_reg <= 1'b0;
      rd_final_reg <= 1'b0;
      rd_lag_reg   <= '0;
    end else begin
      rd_valid_reg <= issue;
      rd_last_reg  <= (k_reg == LAST_K);
      rd_first_reg <= (lag_reg == LOW_L);
      rd_final_reg <= (lag_reg == UP_L);
      rd_lag_reg   <= lag_reg;
    end
  end

  // Multiply-accumulate; at the end of each lag compare against the best so far.
  // Strictly-greater replacement keeps the smaller lag on ties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg      <= '0;
      best_val_reg <= '0;
      best_lag_reg <= '0;
    end else if (start) begin
      acc_reg <= '0;
    end else if (rd_valid_reg) begin
      if (rd_last_reg) begin
        acc_reg <= '0;
        if (rd_first_reg || (acc_sum > best_val_reg)) begin
          best_val_reg <= acc_sum;
          best_lag_reg <= rd_lag_reg;
        end
      end else begin
        acc_reg <= acc_sum;
      end
    end
  end

  // Restoring divider: 32 iterations of (60*SAMPLE_RATE) / (best_lag*HOP)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg       <= '0;
      rem_reg     <= '0;
      div_cnt_reg <= '0;
    end else if (corr_end) begin
      q_reg       <= BPM_NUM;
      rem_reg     <= '0;
      div_cnt_reg <= '0;
    end else if (state_reg == DIV) begin
      rem_reg     <= rem_ge ? 32'(rem_shift - divisor) : rem_shift[31:0];
      q_reg       <= q_next;
      div_cnt_reg <= div_cnt_reg + 5'd1;
    end
  end

  // Result register: updated on the final divide step so it is valid during DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bpm_reg       <= '0;
      bpm_valid_reg <= 1'b0;
    end else begin
      bpm_valid_reg <= (state_reg == DIV) && div_last;
      if ((state_reg == DIV) && div_last) begin
        bpm_reg <= bpm_clamped;
      end
    end
  end

  assign BPM_estimate = bpm_reg;
  assign bpm_valid    = bpm_valid_reg;
  assign state_out    = state_reg;

endmodule

// File: tb/tb_autocorrelation.sv
// Self-checking bench for the autocorrelation tempo estimator: fixed pattern
// table, multi-cycle corner sequences, and randomized buffers checked against
// a queue-based behavioural model.
module tb_autocorrelation;

  localparam int W           = 16;
  localparam int N           = 64;
  localparam int MIN_BPM     = 60;
  localparam int MAX_BPM     = 120;
  localparam int UPPER_LAG   = 800;
  localparam int LOWER_LAG   = 300;
  localparam int SAMPLE_RATE = 12000;
  localparam int FRAME_SIZE  = 1024;
  localparam int STRIDE      = 1;
  localparam int HOP         = FRAME_SIZE / STRIDE;
  localparam int LOW_FR      = (LOWER_LAG * SAMPLE_RATE) / (1000 * HOP);
  localparam int UP_FR       = (UPPER_LAG * SAMPLE_RATE) / (1000 * HOP);
  // States seen 0,1,2,3,0 folded base-4 starting from 0: ((1*4+2)*4+3)*4+0
  localparam int SEQ_FULL    = 108;

  logic         clk = 1'b0;
  logic         reset;
  logic         flux_valid;
  logic [W-1:0] flux_in;
  logic         beat_valid;
  logic [15:0]  BPM_estimate;
  logic         bpm_valid;
  logic [1:0]   state_out;

  always #5 clk = ~clk;

  autocorrelation #(
    .W(W), .N(N), .MIN_BPM(MIN_BPM), .MAX_BPM(MAX_BPM),
    .UPPER_LAG(UPPER_LAG), .LOWER_LAG(LOWER_LAG),
    .SAMPLE_RATE(SAMPLE_RATE), .FRAME_SIZE(FRAME_SIZE), .STRIDE(STRIDE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flux_valid(flux_valid),
    .flux_in(flux_in),
    .beat_valid(beat_valid),
    .BPM_estimate(BPM_estimate),
    .bpm_valid(bpm_valid),
    .state_out(state_out)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned hist[$];   // everything the DUT accepted, oldest first

  typedef struct {
    int kind;       // 0: near-constant 100..110, 1: impulse train of 1000
    int period;
    int n_samples;
    int exp_bpm;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Reference: autocorrelation over the last N accepted samples, plain loops.
  function automatic int model_bpm();
    longint unsigned r, best;
    int best_l, raw, base;
    best = 0;
    best_l = LOW_FR;
    base = hist.size() - N;
    for (int L = LOW_FR; L <= UP_FR; L++) begin
      r = 0;
      for (int k = L; k < N; k++)
        r += longint'(hist[base + k]) * longint'(hist[base + k - L]);
      if (L == LOW_FR || r > best) begin
        best = r;
        best_l = L;
      end
    end
    raw = (60 * SAMPLE_RATE) / (best_l * HOP);
    if (raw < MIN_BPM) raw = MIN_BPM;
    if (raw > MAX_BPM) raw = MAX_BPM;
    return raw;
  endfunction

  task automatic push(input int v, input bit beat);
    @(negedge clk);
    flux_valid = 1'b1;
    flux_in    = W'(v);
    beat_valid = beat;
    hist.push_back(v);
    if (hist.size() > 2 * N) void'(hist.pop_front());
  endtask

  task automatic beat_only();
    @(negedge clk);
    flux_valid = 1'b0;
    beat_valid = 1'b1;
  endtask

  // Watch n cycles with inputs idle; the FSM must stay in IDLE with no pulse.
  task automatic watch_quiet(input string name, input int n);
    int busy_cnt, pulse_cnt;
    busy_cnt = 0;
    pulse_cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      flux_valid = 1'b0;
      beat_valid = 1'b0;
      if (state_out != 2'd0) busy_cnt++;
      if (bpm_valid) pulse_cnt++;
    end
    check({name, "_state_busy_cycles"}, busy_cnt, 0);
    check({name, "_pulses"}, pulse_cnt, 0);
    $display("txn %s: idle %0d cycles, busy=%0d pulses=%0d", name, n, busy_cnt, pulse_cnt);
  endtask

  // Called right after the trigger has been driven; observes 500 cycles.
  task automatic run_txn(input string name, input int exp_bpm, input bit busy, output int est);
    int pulses, lat, seq, last;
    est = -1; pulses = 0; lat = -1; seq = 0; last = 0;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(negedge clk);
      flux_valid = 1'b0;
      beat_valid = 1'b0;
      if (busy && cyc < 400) begin
        if (cyc % 37 == 5) begin
          flux_valid = 1'b1;
          flux_in    = W'($urandom);
        end
        if (cyc % 53 == 7) beat_valid = 1'b1;
      end
      if (int'(state_out) != last) begin
        last = int'(state_out);
        seq  = seq * 4 + last;
      end
      if (bpm_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = cyc;
          est = int'(BPM_estimate);
        end
      end
    end
    check({name, "_bpm"}, est, exp_bpm);
    check({name, "_pulses"}, pulses, 1);
    check({name, "_latency_in_480"}, int'(lat >= 1 && lat <= 480), 1);
    check({name, "_state_seq"}, seq, SEQ_FULL);
    $display("txn %s: bpm=%0d expected=%0d latency=%0d pulses=%0d", name, est, exp_bpm, lat, pulses);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int est, est1, exp_v, per, phase, v;

    vecs[0] = '{kind: 0, period: 0, n_samples: 70, exp_bpm: 120};
    vecs[1] = '{kind: 1, period: 6, n_samples: 64, exp_bpm: 117};
    vecs[2] = '{kind: 1, period: 9, n_samples: 64, exp_bpm: 78};
    vecs[3] = '{kind: 1, period: 4, n_samples: 64, exp_bpm: 120};

    reset      = 1'b0;
    flux_valid = 1'b0;
    flux_in    = '0;
    beat_valid = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    check("reset_bpm", int'(BPM_estimate), 0);
    check("reset_valid", int'(bpm_valid), 0);
    check("reset_state", int'(state_out), 0);
    reset = 1'b1;
    $display("txn reset: bpm=%0d valid=%0d state=%0d", BPM_estimate, bpm_valid, state_out);

    // Underfilled buffer: 40 samples, then 63 samples, trigger ignored
    for (int k = 0; k < 40; k++) push($urandom_range(0, 1000), 1'b0);
    beat_only();
    watch_quiet("underfill40", 60);
    for (int k = 0; k < 23; k++) push($urandom_range(0, 1000), 1'b0);
    beat_only();
    watch_quiet("underfill63", 60);

    // Table-driven patterns; the last sample carries the trigger
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < vecs[i].n_samples; k++) begin
        if (vecs[i].kind == 0) v = $urandom_range(100, 110);
        else v = (k % vecs[i].period == 0) ? 1000 : 0;
        push(v, k == vecs[i].n_samples - 1);
      end
      exp_v = model_bpm();
      run_txn($sformatf("table%0d", i), vecs[i].exp_bpm, 1'b0, est);
      check($sformatf("table%0d_model", i), est, exp_v);
    end

    // Busy: pulses during CORR/DIV ignored; re-trigger gives the same answer
    for (int k = 0; k < N; k++) begin
      v = (k % 7 == 2) ? $urandom_range(3000, 4000) : $urandom_range(0, 300);
      push(v, k == N - 1);
    end
    exp_v = model_bpm();
    run_txn("busy", exp_v, 1'b1, est1);
    beat_only();
    run_txn("retrigger", exp_v, 1'b0, est);
    check("retrigger_same", est, est1);

    // Reset asserted in the middle of CORR aborts with no output
    for (int k = 0; k < N; k++) push($urandom_range(0, 5000), k == N - 1);
    repeat (50) begin
      @(negedge clk);
      flux_valid = 1'b0;
      beat_valid = 1'b0;
    end
    check("midcorr_state_before", int'(state_out), 1);
    #2 reset = 1'b0;
    #1;
    check("midcorr_state_async", int'(state_out), 0);
    check("midcorr_valid_async", int'(bpm_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    watch_quiet("after_abort", 500);

    // Randomized impulse trains with noise against the model
    for (int r = 0; r < 6; r++) begin
      per   = $urandom_range(3, 12);
      phase = $urandom_range(0, per - 1);
      for (int k = 0; k < N; k++) begin
        v = $urandom_range(0, 200);
        if (k % per == phase) v += $urandom_range(2000, 4000);
        push(v, k == N - 1);
      end
      exp_v = model_bpm();
      run_txn($sformatf("rand%0d_p%0d", r, per), exp_v, 1'b0, est);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/autocorrelation.md
Name: autocorrelation

Overview:
Tempo estimator downstream of the spectral-flux onset detector. Keeps the last N flux frames in a circular buffer. On a beat trigger it autocorrelates the buffer over a lag window that corresponds to a beat period range, picks the strongest lag, and converts it to a clamped BPM estimate. The result feeds the tempo display/control logic.

Parameters:
W, 16, flux sample width (unsigned)
N, 64, history buffer depth in frames (power of two)
MIN_BPM, 60, lower clamp of BPM output
MAX_BPM, 120, upper clamp of BPM output
UPPER_LAG, 800, longest beat period searched, in ms
LOWER_LAG, 300, shortest beat period searched, in ms
SAMPLE_RATE, 12000, audio sample rate in Hz
FRAME_SIZE, 1024, analysis frame size in samples
STRIDE, 1, frame overlap factor; hop HOP = FRAME_SIZE/STRIDE samples

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
flux_valid  in  1  flux_in holds a new frame this cycle
flux_in  in  W  unsigned spectral flux value
beat_valid  in  1  trigger: start a BPM computation
BPM_estimate  out  16  last computed, clamped BPM (integer)
bpm_valid  out  1  one-cycle pulse when BPM_estimate updates
state_out  out  2  FSM state: 0 IDLE, 1 CORR, 2 DIV, 3 DONE

Behaviour:
- Elaboration constants: LOWER_LAG_FR = floor(LOWER_LAG*SAMPLE_RATE/(1000*HOP)) = 3 at defaults; UPPER_LAG_FR = floor(UPPER_LAG*SAMPLE_RATE/(1000*HOP)) = 9 at defaults. Required: 1 <= LOWER_LAG_FR <= UPPER_LAG_FR < N.
- Reset (reset=0, asynchronous): buffer pointer, fill count, accumulators and best-lag cleared; state IDLE; BPM_estimate=0; bpm_valid=0. Buffer contents need not be cleared. Reset asserted mid-computation aborts it with no output.
- Buffer: in IDLE, each flux_valid writes flux_in at the write pointer; the pointer increments mod N; the fill count saturates at N. flux_valid is ignored outside IDLE, so the buffer is frozen during a computation.
- Trigger: beat_valid in IDLE with fill count == N starts a computation (next state CORR). If flux_valid and beat_valid are asserted in the same cycle, the sample is written first and included. beat_valid is ignored when the buffer is not full or the FSM is not in IDLE.
- Sample ordering: x[0] is the oldest sample and x[N-1] the newest, i.e. x[k] = buf[(wp+k) mod N].
- CORR: for each L from LOWER_LAG_FR to UPPER_LAG_FR in ascending order, compute R(L) = sum over k=L..N-1 of x[k]*x[k-L].
  - One multiply-accumulate per cycle. The accumulator is 2W+log2(N) bits and unsigned, so it never overflows.
  - R is not normalised.
  - Best tracking: the first lag initialises the best value; a later lag replaces it only if strictly greater, so ties keep the smaller lag.
- DIV: computes BPM_raw = floor(60*SAMPLE_RATE/(best_L*HOP)) with a sequential restoring divider of 32 cycles or fewer.
- DONE: BPM_estimate <= clamp(BPM_raw, MIN_BPM, MAX_BPM); bpm_valid=1 for exactly one cycle; then IDLE. BPM_estimate holds until the next DONE.
- Latency: bpm_valid is asserted at most 480 cycles after the trigger edge at default parameters (CORR needs 406 MACs).
- state_out reflects the registered state every cycle.

Test Plan:
- Reset: hold reset=0 for 5 cycles -> BPM_estimate=0, bpm_valid=0, state_out=0. Assert reset mid-CORR -> state_out=0 immediately, no bpm_valid.
- Underfilled buffer: 40 flux samples then beat_valid -> state_out stays 0, no bpm_valid.
- Near-constant flux: 70 samples of 100..110 random, then flux_valid+beat_valid together -> lag 3 wins, BPM_raw 234, BPM_estimate=120, one bpm_valid pulse within 480 cycles, state sequence 0->1->2->3->0.
- Impulse train period 6 frames (1000 every 6th sample, else 0; 64 samples) -> best lag 6, BPM_estimate=117.
- Impulse train period 9 -> BPM_estimate=78. Impulse train period 4 -> lag 4 wins over lag 8, BPM_raw 175, BPM_estimate=120.
- Busy behaviour: beat_valid and flux_valid pulses during CORR/DIV -> ignored. A second trigger after returning to IDLE recomputes the identical result.
